// File: rtl/vecmul_channel_scheduler.sv
// vecmul_channel_scheduler
//
// Time-multiplexes one shared vector-multiply datapath across every output
// channel of a layer. A feature vector is accepted and held on the datapath
// inputs. The weight/bias ROM address then steps through the channels, one
// per cycle. A tagged valid pipeline of depth ROM_LATENCY+DP_LATENCY follows
// each issued channel to the point where its result appears on dp_result.
// That result is written into out_vector[tag]. The completed vector is then
// presented with a valid/ready handshake.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset; clears all state
//   in_valid    feature vector offered
//   in_ready    block can accept a vector (IDLE only)
//   in_feature  INPUT_DIM x (PRECISION+1) signed feature vector
//   dp_feature  held feature vector driven to the datapath
//   wrom_en     weight/bias ROM read strobe
//   wrom_addr   channel index being read (0 whenever wrom_en=0)
//   dp_result   requantised datapath result, PRECISION bits
//   out_valid   out_vector complete
//   out_ready   consumer accepts out_vector
//   out_vector  OUTPUT_DIM x PRECISION results, index = channel
//   busy        block is not IDLE
module vecmul_channel_scheduler #(
  parameter int INPUT_DIM   = 4,
  parameter int OUTPUT_DIM  = 16,
  parameter int PRECISION   = 8,
  parameter int ROM_LATENCY = 1,
  parameter int DP_LATENCY  = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [INPUT_DIM-1:0][PRECISION:0] in_feature,
  output logic signed [INPUT_DIM-1:0][PRECISION:0] dp_feature,
  output logic                                   wrom_en,
  output logic [$clog2(OUTPUT_DIM)-1:0]          wrom_addr,
  input  logic [PRECISION-1:0]                   dp_result,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUTPUT_DIM-1:0][PRECISION-1:0]   out_vector,
  output logic                                   busy
);

  localparam int L  = ROM_LATENCY + DP_LATENCY;
  localparam int AW = $clog2(OUTPUT_DIM);
  localparam logic [AW-1:0] LAST_CH = AW'(OUTPUT_DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_OUTPUT
  } state_t;

  state_t state_reg, state_next;

  // wrom_addr_reg doubles as the channel counter while issuing.
  logic          wrom_en_reg,   wrom_en_next;
  logic [AW-1:0] wrom_addr_reg, wrom_addr_next;
  logic          in_ready_reg,  in_ready_next;
  logic          out_valid_reg, out_valid_next;
  logic          busy_reg,      busy_next;
  logic          load_feature;

  logic signed [INPUT_DIM-1:0][PRECISION:0] dp_feature_reg;
  logic [OUTPUT_DIM-1:0][PRECISION-1:0]     out_vector_reg;

  // Tagged valid pipeline; stage L-1 lines up with dp_result.
  logic [L-1:0]  sr_valid_reg;
  logic [AW-1:0] sr_tag_reg [L];

  logic sr_out_valid;
  logic last_exit;

  assign sr_out_valid = sr_valid_reg[L-1];
  // Channels leave the pipeline in issue order, so the final channel leaving
  // means nothing else is in flight.
  assign last_exit    = sr_out_valid && (sr_tag_reg[L-1] == LAST_CH);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      wrom_en_reg   <= 1'b0;
      wrom_addr_reg <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wrom_en_reg   <= wrom_en_next;
      wrom_addr_reg <= wrom_addr_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
    end
  end

  // Outputs are computed from the next state so that they are registered
  // and line up with the state they describe.
  always_comb begin
    state_next     = state_reg;
    wrom_en_next   = 1'b0;
    wrom_addr_next = '0;
    load_feature   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          load_feature   = 1'b1;
          state_next     = ST_ISSUE;
          wrom_en_next   = 1'b1;
          wrom_addr_next = '0;
        end
      end
      ST_ISSUE: begin
        if (wrom_addr_reg == LAST_CH) begin
          state_next = ST_DRAIN;
        end else begin
          wrom_en_next   = 1'b1;
          wrom_addr_next = wrom_addr_reg + AW'(1);
        end
      end
      ST_DRAIN: begin
        if (last_exit) begin
          state_next = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    in_ready_next  = (state_next == ST_IDLE);
    busy_next      = (state_next != ST_IDLE);
    out_valid_next = (state_next == ST_OUTPUT);
  end

  // ------------------------------------------------------- feature hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_feature_reg <= '0;
    end else if (load_feature) begin
      dp_feature_reg <= in_feature;
    end
  end

  // ------------------------------------------------ tagged valid pipeline
  // The issue registers feed stage 0 directly. An idle cycle pushes
  // valid=0 with tag 0.
  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            sr_valid_reg[0] <= 1'b0;
            sr_tag_reg[0]   <= '0;
          end else begin
            sr_valid_reg[0] <= wrom_en_reg;
            sr_tag_reg[0]   <= wrom_addr_reg;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            sr_valid_reg[gi] <= 1'b0;
            sr_tag_reg[gi]   <= '0;
          end else begin
            sr_valid_reg[gi] <= sr_valid_reg[gi-1];
            sr_tag_reg[gi]   <= sr_tag_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------- result capture
  // Entries persist across vectors. Every channel is rewritten before the
  // next out_valid, so no clearing is needed.
  generate
    for (genvar gi = 0; gi < OUTPUT_DIM; gi++) begin : g_slot
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_vector_reg[gi] <= '0;
        end else if (sr_out_valid && (sr_tag_reg[L-1] == AW'(gi))) begin
          out_vector_reg[gi] <= dp_result;
        end
      end
    end
  endgenerate

  assign in_ready   = in_ready_reg;
  assign dp_feature = dp_feature_reg;
  assign wrom_en    = wrom_en_reg;
  assign wrom_addr  = wrom_addr_reg;
  assign out_valid  = out_valid_reg;
  assign out_vector = out_vector_reg;
  assign busy       = busy_reg;

endmodule
